instr_encoder: RTL
==================

# instr_encoder

Instruction encoder for the pipelined LEGv8 CPU: the inverse of the control decoder. It accepts structured instruction requests (kind, registers, immediate) over a valid/ready handshake, packs them into 32-bit LEGv8 machine words, and assigns each one a sequential byte address. Results sit in a 2-entry output buffer that feeds the instruction-memory loader and the self-test program generator.

## Interface
- `ADDR_W`, default 10: width of the instruction byte address. The counter wraps modulo 2^ADDR_W.
- `clk` input, 1: clock.
- `rst` input, 1: synchronous, active-low reset.
- `in_valid` input, 1: request valid.
- `in_ready` output, 1: block can accept a request this cycle.
- `in_kind` input, 4: instruction kind. 0 B, 1 B.cond, 2 BL, 3 BR, 4 CBZ, 5 ADDI, 6 ADDS, 7 LDUR, 8 STUR, 9 SUBS. Values 10–15 are illegal.
- `in_rd` input, 5: Rd or Rt field.
- `in_rn` input, 5: Rn field.
- `in_rm` input, 5: Rm field.
- `in_cond` input, 4: B.cond condition code.
- `in_imm` input, 26: immediate, two's complement (ADDI uses it as unsigned).
- `out_valid` output, 1: buffer head is valid.
- `out_ready` input, 1: consumer accepts the buffer head.
- `out_instr` output, 32: encoded word at the buffer head.
- `out_addr` output, ADDR_W: byte address of the buffer head.
- `err` output, 1: sticky error flag.
- `err_code` output, 2: 01 illegal kind, 10 immediate out of range.
- `clr_err` input, 1: clears the error and returns the FSM to RUN.

## Operation
- **Encodings** (the remaining bits of each word are 0):
  - B: [31:26]=000101, [25:0]=imm26.
  - BL: [31:26]=100101, [25:0]=imm26.
  - B.cond: [31:24]=01010100, [23:5]=imm19, [4:0]={0,in_cond}.
  - CBZ: [31:24]=10110100, [23:5]=imm19, [4:0]=Rd.
  - BR: [31:21]=11010110000, [9:5]=Rn.
  - ADDI: [31:22]=1001000100, [21:10]=imm12, [9:5]=Rn, [4:0]=Rd.
  - ADDS: [31:21]=10101011000, [20:16]=Rm, [15:10]=0, [9:5]=Rn, [4:0]=Rd.
  - SUBS: same layout as ADDS with [31:21]=11101011000.
  - LDUR: [31:21]=11111000010, [20:12]=imm9, [11:10]=00, [9:5]=Rn, [4:0]=Rt.
  - STUR: same layout as LDUR with [31:21]=11111000000.
- **Immediate fields:** imm26, imm19, imm12 and imm9 are the low bits of `in_imm`.
- **FSM states:** RUN and ERROR.
  - `in_ready` = (state==RUN) && (buffer count < 2).
- **Accept** happens on `in_valid && in_ready`.
  - Legal request: push {word, addr_ctr} into the buffer, then addr_ctr += 4 (wrapping).
  - Illegal kind: nothing is pushed, addr_ctr is held, `err`=1, `err_code`=01, state goes to ERROR.
- **ERROR state:**
  - `in_ready`=0.
  - The buffer keeps draining normally.
  - `clr_err`=1 sets `err`=0 and `err_code`=00, and returns the FSM to RUN on the next edge.
  - `clr_err` in RUN has no effect.
- **Buffer:** 2-entry FIFO. Pop on `out_valid && out_ready`.
  - A simultaneous push and pop at count 1 leaves count at 1.
  - When count is 2, `in_ready` is 0: there is no pass-through while full.
  - The buffer never overflows or underflows.
- **Error versus illegal request:** if an illegal request and a pending `clr_err` coincide in RUN, the illegal request wins and the FSM enters ERROR.

## Timing
- **Reset** (`rst`=0 at a rising edge) forces:
  - buffer empty, `out_valid`=0, `out_instr`=0, `out_addr`=0;
  - addr_ctr=0, state=RUN, `err`=0, `err_code`=00;
  - `in_ready`=0 during reset, then 1 on the first cycle after reset is released.
- **Reset mid-operation** discards buffered words with no pop.
- **Latency:** a request accepted at edge N is presented on `out_valid`/`out_instr` after edge N when the buffer was empty (1 cycle).
- **Throughput:** 1 word/cycle while `out_ready` is held at 1.
- `out_instr` and `out_addr` are stable while `out_valid` && !`out_ready`.
- **Address wrap:** the word accepted after address 2^ADDR_W−4 gets address 0.

## Configuration
- **`ENC_RANGE_CHECK_EN` defined:** the immediate is range-checked at acceptance.
  - Limits: imm12 must be 0..4095; imm9 must be −256..255; imm19 must be −2^18..2^18−1. imm26 is always in range.
  - On violation the request is treated like an illegal kind: no push, addr held, `err_code`=10, state goes to ERROR.
- **Not defined:** immediates are silently truncated to the field width, and `err_code`=10 never occurs.

## Test plan
- Reset, then ADDI with Rd=1, Rn=2, imm=5 and `out_ready`=1 → one cycle later `out_valid`=1, `out_instr`=0x91001441, `out_addr`=0.
- Back-to-back B imm=−1 then ADDS Rd=3, Rn=1, Rm=2 → `out_instr` 0x17FFFFFF at addr 0, then 0xAB020023 at addr 4.
- LDUR Rt=5, Rn=1, imm=−8 → 0xF85F8025. Then hold `out_ready`=0 and present 3 requests → exactly 2 are accepted, `in_ready`=0, and the head word stays stable.
- `in_kind`=12 → `err`=1, `err_code`=01, `in_ready`=0, addr not advanced. Pulse `clr_err` → `in_ready`=1 and the next word gets the prior address.
- ADDI imm=4096 → with `ENC_RANGE_CHECK_EN`: `err_code`=10 and no output. Without it: `out_instr`=0x91000000 (imm12 truncated to 0, Rn=Rd=0).
- Preload addr_ctr to 2^ADDR_W−4 by issuing 255 words, then issue 2 more → addresses 0x3FC then 0x000. Assert `rst`=0 with the buffer full → `out_valid`=0 next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs structured LEGv8 instruction requests into 32-bit
// machine words, tags each with a sequential byte address and queues them
// in a 2-entry output FIFO. Optional macro ENC_RANGE_CHECK_EN enables
// immediate range checking at acceptance (err_code 10 on violation).
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [3:0]        in_cond,
  input  logic [25:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              clr_err
);
  typedef enum logic {RUN = 1'b0, ERROR = 1'b1} state_t;
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  state_t            state, state_nxt;
  entry_t            fifo [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr_ctr;
  logic              live;
  logic [31:0]       word;
  logic              kind_ok, imm_ok;
  logic              accept, push, pop, fault;

  // Field packing per instruction kind; unknown kinds flag kind_ok=0
  always_comb begin
    word    = '0;
    kind_ok = 1'b1;
    case (in_kind)
      4'd0:    word = {6'b000101, in_imm};
      4'd1:    word = {8'b01010100, in_imm[18:0], 1'b0, in_cond};
      4'd2:    word = {6'b100101, in_imm};
      4'd3:    word = {11'b11010110000, 11'b0, in_rn, 5'b0};
      4'd4:    word = {8'b10110100, in_imm[18:0], in_rd};
      4'd5:    word = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
      4'd6:    word = {11'b10101011000, in_rm, 6'b0, in_rn, in_rd};
      4'd7:    word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
      4'd8:    word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
      4'd9:    word = {11'b11101011000, in_rm, 6'b0, in_rn, in_rd};
      default: kind_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediate must be representable in its field: signed fields need the
  // upper bits to be a pure sign extension, imm12 must be non-negative
  always_comb begin
    imm_ok = 1'b1;
    case (in_kind)
      4'd1, 4'd4: imm_ok = (&in_imm[25:18]) || !(|in_imm[25:18]);
      4'd5:       imm_ok = !(|in_imm[25:12]);
      4'd7, 4'd8: imm_ok = (&in_imm[25:8]) || !(|in_imm[25:8]);
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  // live holds in_ready low through reset and rises the cycle after release
  assign in_ready  = live && (state == RUN) && (count != 2'd2);
  assign accept    = in_valid && in_ready;
  assign fault     = accept && !(kind_ok && imm_ok);
  assign push      = accept && kind_ok && imm_ok;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = fifo[rd_ptr].instr;
  assign out_addr  = fifo[rd_ptr].addr;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // FSM next state: a bad request enters ERROR, clr_err leaves it
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (fault)   state_nxt = ERROR;
      ERROR:   if (clr_err) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Sticky error flag and code; faults only occur in RUN so they win over clr_err
  always_ff @(posedge clk) begin
    if (!rst) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (fault) begin
      err      <= 1'b1;
      err_code <= kind_ok ? 2'b10 : 2'b01;
    end else if (state == ERROR && clr_err) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end
  end

  // FIFO storage, pointers, occupancy and address counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo[0]  <= '0;
      fifo[1]  <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      addr_ctr <= '0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) begin
        fifo[wr_ptr] <= '{instr: word, addr: addr_ctr};
        wr_ptr       <= ~wr_ptr;
        addr_ctr     <= addr_ctr + ADDR_W'(4);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
